// File: rtl/chacha_stream_ctrl.sv
// Bit-serial ChaCha stream sequencer: keystream fetch, bit walk, XOR.
// Optional wrap guard (EXHAUSTED state) enabled by CHACHA_CTRL_WRAP_GUARD_EN.
module chacha_stream_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  init_value,
  input  logic        pt_valid,
  input  logic        pt_bit,
  output logic        pt_ready,
  output logic        ct_valid,
  output logic        ct_bit,
  input  logic        ct_ready,
  output logic [1:0]  ks_counter,
  input  logic [15:0] ks_data,
  output logic [3:0]  bit_idx,
  output logic        busy,
  output logic        exhausted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RUN
`ifdef CHACHA_CTRL_WRAP_GUARD_EN
    , S_EXH
`endif
  } state_t;

  state_t      state, state_nx;
  logic [15:0] ks_reg;
  logic        accept;
  logic        start_ok;
  logic        last_bit;

`ifdef CHACHA_CTRL_WRAP_GUARD_EN
  logic [2:0]  blk_cnt;
`endif

  assign accept   = (state == S_RUN) && pt_valid && pt_ready;
  assign last_bit = (bit_idx == 4'd15);

`ifdef CHACHA_CTRL_WRAP_GUARD_EN
  assign start_ok = start && ((state == S_IDLE) || (state == S_EXH));
`else
  assign start_ok = start && (state == S_IDLE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start_ok) state_nx = S_FETCH;
        S_FETCH: state_nx = S_RUN;
        S_RUN: begin
          if (accept && last_bit) begin
`ifdef CHACHA_CTRL_WRAP_GUARD_EN
            // 4th block done: counter is back at init_value
            if (blk_cnt == 3'd3) state_nx = S_EXH;
            else                 state_nx = S_FETCH;
`else
            state_nx = S_FETCH;
`endif
          end
        end
`ifdef CHACHA_CTRL_WRAP_GUARD_EN
        S_EXH:   if (start_ok) state_nx = S_FETCH;
`endif
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pt_ready  = 1'b0;
    busy      = (state != S_IDLE);
    exhausted = 1'b0;
    if (state == S_RUN) pt_ready = !ct_valid || ct_ready;
`ifdef CHACHA_CTRL_WRAP_GUARD_EN
    exhausted = (state == S_EXH);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks_counter <= 2'd0;
      bit_idx    <= 4'd0;
      ct_valid   <= 1'b0;
      ct_bit     <= 1'b0;
      ks_reg     <= 16'd0;
    end else if (stop) begin
      ct_valid <= 1'b0;
      bit_idx  <= 4'd0;
    end else begin
      if (start_ok) begin
        ks_counter <= init_value;
        bit_idx    <= 4'd0;
      end
      if (state == S_FETCH) ks_reg <= ks_data;
      if (accept) begin
        ct_bit   <= pt_bit ^ ks_reg[4'd15 - bit_idx];
        ct_valid <= 1'b1;
        bit_idx  <= bit_idx + 4'd1;
        if (last_bit) ks_counter <= ks_counter + 2'd1;
      end else if (ct_valid && ct_ready) begin
        ct_valid <= 1'b0;
      end
    end
  end

`ifdef CHACHA_CTRL_WRAP_GUARD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= 3'd0;
    end else if (!stop) begin
      if (start_ok)
        blk_cnt <= 3'd0;
      else if (accept && last_bit)
        blk_cnt <= blk_cnt + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl.
// Keystream stub returns a fixed word per counter value.
module tb_chacha_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  init_value;
  logic        pt_valid;
  logic        pt_bit;
  logic        pt_ready;
  logic        ct_valid;
  logic        ct_bit;
  logic        ct_ready;
  logic [1:0]  ks_counter;
  logic [15:0] ks_data;
  logic [3:0]  bit_idx;
  logic        busy;
  logic        exhausted;

  int checks = 0;
  int failures = 0;
  logic [1:0]  exp_cnt;
  logic [15:0] kw;

  always #5 clk = ~clk;

  function automatic logic [15:0] ks_of(input logic [1:0] c);
    case (c)
      2'd0:    ks_of = 16'hA5C3;
      2'd1:    ks_of = 16'h3C5A;
      2'd2:    ks_of = 16'hF00F;
      default: ks_of = 16'h6996;
    endcase
  endfunction

  assign ks_data = ks_of(ks_counter);

  chacha_stream_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .init_value (init_value),
    .pt_valid   (pt_valid),
    .pt_bit     (pt_bit),
    .pt_ready   (pt_ready),
    .ct_valid   (ct_valid),
    .ct_bit     (ct_bit),
    .ct_ready   (ct_ready),
    .ks_counter (ks_counter),
    .ks_data    (ks_data),
    .bit_idx    (bit_idx),
    .busy       (busy),
    .exhausted  (exhausted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ks_counter"}, 32'(ks_counter), 0);
    chk({tag, "_bit_idx"}, 32'(bit_idx), 0);
    chk({tag, "_ct_valid"}, 32'(ct_valid), 0);
    chk({tag, "_ct_bit"}, 32'(ct_bit), 0);
    chk({tag, "_pt_ready"}, 32'(pt_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_exhausted"}, 32'(exhausted), 0);
  endtask

  // Entered during FETCH with pt_valid=1, ct_ready=1; leaves in next FETCH.
  task automatic run_block(input string tag, input logic p);
    logic [15:0] k;
    k = ks_of(exp_cnt);
    tick();
    chk({tag, "_run_ready"}, 32'(pt_ready), 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, "_ct_valid"}, 32'(ct_valid), 1);
      chk({tag, "_ct_bit"}, 32'(ct_bit), 32'(p ^ k[15-i]));
      chk({tag, "_bit_idx"}, 32'(bit_idx), 32'((i + 1) % 16));
    end
    exp_cnt = exp_cnt + 2'd1;
    chk({tag, "_ks_counter"}, 32'(ks_counter), 32'(exp_cnt));
  endtask

  task automatic do_start(input logic [1:0] v);
    init_value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = v;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    init_value = 2'd0; pt_valid = 1'b0; pt_bit = 1'b0;
    ct_ready = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // block walk, pt all zero
    do_start(2'd0);
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_ready0", 32'(pt_ready), 0);
    pt_valid = 1'b1; pt_bit = 1'b0;
    #1;
    chk("fetch_ready_pv", 32'(pt_ready), 0);
    run_block("walk", 1'b0);
    chk("walk_fetch_ready", 32'(pt_ready), 0);
    chk("walk_bidx", 32'(bit_idx), 0);

    // restart and XOR with all ones
    stop = 1'b1; pt_valid = 1'b0;
    tick();
    stop = 1'b0;
    chk("stop_idle_busy", 32'(busy), 0);
    chk("stop_hold_cnt", 32'(ks_counter), 1);
    do_start(2'd0);
    pt_valid = 1'b1; pt_bit = 1'b1;
    run_block("xor", 1'b1);

    // backpressure on a fresh session
    stop = 1'b1; pt_valid = 1'b0;
    tick();
    stop = 1'b0;
    do_start(2'd0);
    pt_valid = 1'b1; pt_bit = 1'b1;
    tick();
    tick();
    chk("bp_first_bit", 32'(ct_bit), 0);
    ct_ready = 1'b0;
    #1;
    chk("bp_ready_low", 32'(pt_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(ct_valid), 1);
      chk("bp_hold_bit", 32'(ct_bit), 0);
      chk("bp_hold_idx", 32'(bit_idx), 1);
      chk("bp_hold_ready", 32'(pt_ready), 0);
    end
    ct_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(pt_ready), 1);
    tick();
    chk("bp_refill_valid", 32'(ct_valid), 1);
    chk("bp_refill_bit", 32'(ct_bit), 1);
    chk("bp_refill_idx", 32'(bit_idx), 2);
    for (int i = 2; i < 7; i++) begin
      tick();
      kw = ks_of(2'd0);
      chk("bp_stream_bit", 32'(ct_bit), 32'(1'b1 ^ kw[15-i]));
    end
    chk("pre_stop_idx", 32'(bit_idx), 7);

    // stop and start together at bit_idx 7
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_ct_valid", 32'(ct_valid), 0);
    chk("ss_bit_idx", 32'(bit_idx), 0);
    chk("ss_pt_ready", 32'(pt_ready), 0);
    chk("ss_ks_hold", 32'(ks_counter), 0);

    // counter wrap 3 -> 0
    pt_bit = 1'b0;
    do_start(2'd3);
    chk("wrap_init_cnt", 32'(ks_counter), 3);
    run_block("wrap", 1'b0);
    chk("wrap_cnt0", 32'(ks_counter), 0);
    chk("wrap_fetch_ready", 32'(pt_ready), 0);
    tick();
    chk("wrap_run_ready", 32'(pt_ready), 1);

    // guard: 64 accepts from init 1
    stop = 1'b1;
    tick();
    stop = 1'b0;
    do_start(2'd1);
    pt_bit = 1'b1;
    run_block("g0", 1'b1);
    run_block("g1", 1'b1);
    run_block("g2", 1'b1);
    run_block("g3", 1'b1);
`ifdef CHACHA_CTRL_WRAP_GUARD_EN
    chk("guard_exh", 32'(exhausted), 1);
    chk("guard_ready", 32'(pt_ready), 0);
    tick();
    chk("guard_no_accept", 32'(bit_idx), 0);
    chk("guard_drained", 32'(ct_valid), 0);
    chk("guard_exh_hold", 32'(exhausted), 1);
    chk("guard_cnt", 32'(ks_counter), 1);
    do_start(2'd2);
    chk("guard_restart_exh", 32'(exhausted), 0);
    chk("guard_restart_cnt", 32'(ks_counter), 2);
    tick();
`else
    chk("noguard_exh", 32'(exhausted), 0);
    chk("noguard_cnt", 32'(ks_counter), 1);
    tick();
    chk("noguard_ready", 32'(pt_ready), 1);
    tick();
    kw = ks_of(2'd1);
    chk("noguard_65_idx", 32'(bit_idx), 1);
    chk("noguard_65_bit", 32'(ct_bit), 32'(1'b1 ^ kw[15]));
`endif

    // async reset between edges mid-run
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("areset");
    pt_valid = 1'b0;
    tick();
    reset = 1'b0;
    do_start(2'd2);
    chk("post_reset_busy", 32'(busy), 1);
    chk("post_reset_cnt", 32'(ks_counter), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
